serial_divider: RTL and testbench

Signed sequential divider producing one quotient bit per clock using restoring division on operand magnitudes, with a final sign-correction step. It is the inverse datapath of the serial-parallel multiplier and shares its start/done handshake style. The self-checking benches for both blocks can therefore drive them back-to-back: multiply, then divide the product's low word to recover the operand.

---
 rtl/serial_divider.sv | 201 ++++++++++++++++++++
 tb/tb_serial_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes, then sign fix-up.
// Optional macro SERIAL_DIV_DBZ_EN enables the divide-by-zero short path and the dbz flag.
module serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] DD,
  input  logic [WIDTH-1:0] DR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef SERIAL_DIV_DBZ_EN
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    neg = ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) mag = neg(v);
    else            mag = v;
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;   // dividend magnitude, shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              zflag_q, zflag_d;
  logic [WIDTH-1:0]  q_res_q, q_res_d;
  logic [WIDTH-1:0]  r_res_q, r_res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic [WIDTH:0]    trial_s;
  logic              ge_s;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SERIAL_DIV_DBZ_EN
          if (DR == ZERO) state_d = S_FIX;
          else            state_d = S_CALC;
`else
          state_d = S_CALC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) state_d = S_FIX;
        else                   state_d = S_CALC;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath and output next values
  always_comb begin
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zflag_d = zflag_q;
    q_res_d = q_res_q;
    r_res_d = r_res_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    trial_s = {rem_q, dvd_q[WIDTH-1]};
    ge_s    = (trial_s >= {1'b0, dvs_q});
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d  = mag(DD);
          dvs_d  = mag(DR);
          rem_d  = ZERO;
          cnt_d  = CNT_ZERO;
          rneg_d = DD[WIDTH-1];
          qneg_d = DD[WIDTH-1] ^ DR[WIDTH-1];
`ifdef SERIAL_DIV_DBZ_EN
          zflag_d = (DR == ZERO);
`else
          zflag_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        // trial fits in WIDTH bits whenever it is kept, so the subtract can be WIDTH wide
        dvd_d = {dvd_q[WIDTH-2:0], ge_s};
        if (ge_s) rem_d = trial_s[WIDTH-1:0] - dvs_q;
        else      rem_d = trial_s[WIDTH-1:0];
        cnt_d = cnt_q + CNT_ONE;
      end
      S_FIX: begin
`ifdef SERIAL_DIV_DBZ_EN
        if (zflag_q) begin
          dvd_d = ONES;
          if (rneg_q) rem_d = neg(dvd_q);
          else        rem_d = dvd_q;
        end else begin
          if (qneg_q) dvd_d = neg(dvd_q);
          else        dvd_d = dvd_q;
          if (rneg_q) rem_d = neg(rem_q);
          else        rem_d = rem_q;
        end
`else
        if (qneg_q) dvd_d = neg(dvd_q);
        else        dvd_d = dvd_q;
        if (rneg_q) rem_d = neg(rem_q);
        else        rem_d = rem_q;
`endif
      end
      S_DONE: begin
        q_res_d = dvd_q;
        r_res_d = rem_q;
        dbz_d   = zflag_q;
        done_d  = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q   <= ZERO;
      dvs_q   <= ZERO;
      rem_q   <= ZERO;
      cnt_q   <= CNT_ZERO;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zflag_q <= 1'b0;
      q_res_q <= ZERO;
      r_res_q <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zflag_q <= zflag_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q    = q_res_q;
  assign R    = r_res_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed table, handshake corner sequences, random vs. arithmetic model.
module tb_serial_divider;

`ifdef SERIAL_DIV_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif
  localparam int LAT = 34;

  logic        clk, rst_n, start;
  logic [31:0] DD, DR, Q, R;
  logic        busy, done, dbz;
  int          n_vec = 0;
  int          n_err = 0;

  serial_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst_n), .start(start), .DD(DD), .DR(DR),
    .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] dd, dr, q, r;
    logic        z;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic (truncating division, remainder follows dividend)
  function automatic void model(input logic [31:0] dd, input logic [31:0] dr,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z, output int lat);
    longint a, b;
    a = $signed(dd);
    b = $signed(dr);
    if (b == 0) begin
      r   = dd;
      z   = DBZ;
      lat = DBZ ? 2 : LAT;
      q   = (DBZ || a >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
    end else begin
      q   = 32'(a / b);
      r   = 32'(a % b);
      z   = 1'b0;
      lat = LAT;
    end
  endfunction

  task automatic run_op(input string nm, input vec_t v);
    int lat;
    bit busy_ok, hold_ok;
    logic [31:0] q0, r0;
    @(negedge clk);
    q0 = Q; r0 = R;
    DD = v.dd; DR = v.dr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    DD = $urandom; DR = $urandom;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (Q !== q0 || R !== r0) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(v.lat));
    chk({nm, " busy during op"}, 64'(busy_ok), 64'd1);
    chk({nm, " Q/R hold before done"}, 64'(hold_ok), 64'd1);
    chk({nm, " busy at done"}, 64'(busy), 64'd0);
    chk({nm, " Q"}, 64'(Q), 64'(v.q));
    chk({nm, " R"}, 64'(R), 64'(v.r));
    chk({nm, " dbz"}, 64'(dbz), 64'(v.z));
    @(posedge clk); #1;
    chk({nm, " done single pulse"}, 64'(done), 64'd0);
    chk({nm, " Q held"}, 64'(Q), 64'(v.q));
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    int lat;
    bit saw_done;
    tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, LAT};
    tbl[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, LAT};
    tbl[2]  = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, LAT};
    tbl[3]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, LAT};
    tbl[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, LAT};
    tbl[5]  = '{32'd7,          32'h8000_0000,  32'd0,          32'd7,          1'b0, LAT};
    tbl[6]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          DBZ,  DBZ ? 2 : LAT};
    tbl[7]  = '{32'hFFFF_FFFB,  32'd0,          DBZ ? 32'hFFFF_FFFF : 32'd1, 32'hFFFF_FFFB, DBZ, DBZ ? 2 : LAT};
    tbl[8]  = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, LAT};
    tbl[9]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, LAT};
    tbl[10] = '{32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, LAT};
    tbl[11] = '{32'd3,          32'd5,          32'd0,          32'd3,          1'b0, LAT};

    rst_n = 1'b0; start = 1'b0; DD = 32'd0; DR = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset Q", 64'(Q), 64'd0);
    chk("reset R", 64'(R), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(dbz), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op($sformatf("tbl%0d", i), tbl[i]);

    // start held high through done: not accepted in DONE, accepted at the next edge
    @(negedge clk);
    DD = 32'd50; DR = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("b2b first latency", 64'(lat), 64'(LAT));
    chk("b2b first Q", 64'(Q), 64'd10);
    chk("b2b idle in done cycle", 64'(busy), 64'd0);
    DD = 32'd77; DR = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b second accepted", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("b2b second latency", 64'(lat), 64'(LAT));
    chk("b2b second Q", 64'(Q), 64'd11);
    chk("b2b second R", 64'(R), 64'd0);

    // start pulse while busy is ignored
    @(negedge clk);
    DD = 32'd1000; DR = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 9) begin start = 1'b1; DD = 32'd9; DR = 32'd9; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("ignore latency", 64'(lat), 64'(LAT));
    chk("ignore Q", 64'(Q), 64'd333);
    chk("ignore R", 64'(R), 64'd1);
    @(posedge clk); #1;
    chk("ignore no restart", 64'(busy), 64'd0);

    // reset mid-operation
    run_op("pre-reset", tbl[0]);
    @(negedge clk);
    DD = 32'd1000; DR = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst Q", 64'(Q), 64'd0);
    chk("midrst R", 64'(R), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst no done/busy after", 64'(saw_done), 64'd0);
    run_op("post-reset", tbl[8]);

    // random operands vs. arithmetic model
    for (int i = 0; i < 40; i++) begin
      rv.dd = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rv.dd = -rv.dd;
      rv.dr = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rv.dr = -rv.dr;
      if ($urandom_range(0, 15) == 0) rv.dr = 32'd0;
      model(rv.dd, rv.dr, rv.q, rv.r, rv.z, rv.lat);
      run_op($sformatf("rnd%0d %0h/%0h", i, rv.dd, rv.dr), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
